// File: rtl/branch_seq_pkg.sv
// Shared opcode encodings, sequencer state type and field widths for the branch sequencer.
package branch_seq_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_JMP  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_BEQ  = 5'b00010;
  localparam logic [OPC_W-1:0] OP_BNE  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_CALL = 5'b00100;
  localparam logic [OPC_W-1:0] OP_RET  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_BLT  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b00111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } seq_state_t;

endpackage

// File: rtl/branch_seq_stack.sv
// Return-address LIFO: pushes and pops take effect on the clock edge; the top entry is read combinationally.
// Pushes while full and pops while empty are dropped, so the caller owns the fault reporting.
module branch_seq_stack #(
  parameter int PC_W        = 5,
  parameter int STACK_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  logic                             pop,
  input  logic [PC_W-1:0]                  push_data,
  output logic [PC_W-1:0]                  top_data,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(STACK_DEPTH+1)-1:0] level
);

  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);

  logic [PC_W-1:0]  mem [STACK_DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;

  assign wr_idx   = IDX_W'(level);
  assign top_idx  = IDX_W'(level - LVL_W'(1));
  assign top_data = mem[top_idx];
  assign full     = (level == LVL_W'(STACK_DEPTH));
  assign empty    = (level == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= '0;
    end else if (push && !full) begin
      level <= level + LVL_W'(1);
    end else if (pop && !empty) begin
      level <= level - LVL_W'(1);
    end
  end

  // Contents need no reset: nothing is read until a push has written it.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// Next-PC sequencer (jump/branch/call/return, HALT/resume, sticky FAULT); one-cycle latency, accepts while RUN.
// Optional BLT opcode enabled by defining BRANCH_SEQUENCER_BLT_EN; otherwise opcode 00110 falls through to pc+1.
module branch_sequencer
  import branch_seq_pkg::*;
#(
  parameter int PC_W        = 5,
  parameter int DATA_W      = 5,
  parameter int INSTR_W     = 19,
  parameter int STACK_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             instr_valid,
  input  logic [INSTR_W-1:0]               instr,
  input  logic [PC_W-1:0]                  pc,
  input  logic [DATA_W-1:0]                r1,
  input  logic [DATA_W-1:0]                r2,
  input  logic                             resume,
  output logic [PC_W-1:0]                  updatedpc,
  output logic                             pc_valid,
  output logic [INSTR_W-1:0]               instructions,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level,
  output logic                             halted,
  output logic                             fault
);

  seq_state_t       state;
  seq_state_t       next_state;
  logic [OPC_W-1:0] opcode;
  logic [PC_W-1:0]  tgt;
  logic [PC_W-1:0]  inc;
  logic [PC_W-1:0]  next_pc;
  logic [PC_W-1:0]  ret_addr;
  logic             accept;
  logic             do_push;
  logic             do_pop;
  logic             stk_full;
  logic             stk_empty;

  assign opcode = instr[INSTR_W-1 -: OPC_W];
  assign tgt    = instr[PC_W-1:0];
  assign inc    = pc + PC_W'(1);
  assign accept = instr_valid && (state == ST_RUN);

  always_comb begin
    next_pc    = inc;
    next_state = ST_RUN;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    case (opcode)
      OP_JMP: next_pc = tgt;
      OP_BEQ: next_pc = (r1 == r2) ? tgt : inc;
      OP_BNE: next_pc = (r1 != r2) ? tgt : inc;
      OP_CALL: begin
        if (stk_full) begin
          next_pc    = updatedpc;
          next_state = ST_FAULT;
        end else begin
          next_pc = tgt;
          do_push = accept;
        end
      end
      OP_RET: begin
        if (stk_empty) begin
          next_pc    = updatedpc;
          next_state = ST_FAULT;
        end else begin
          next_pc = ret_addr;
          do_pop  = accept;
        end
      end
`ifdef BRANCH_SEQUENCER_BLT_EN
      OP_BLT: next_pc = (r1 < r2) ? tgt : inc;
`endif
      OP_HALT: begin
        next_pc    = pc;
        next_state = ST_HALT;
      end
      default: next_pc = inc;
    endcase
  end

  branch_seq_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (inc),
    .top_data  (ret_addr),
    .full      (stk_full),
    .empty     (stk_empty),
    .level     (stack_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_RUN;
      updatedpc    <= '0;
      pc_valid     <= 1'b0;
      instructions <= '0;
      halted       <= 1'b0;
      fault        <= 1'b0;
    end else begin
      pc_valid <= 1'b0;
      case (state)
        ST_RUN: begin
          if (instr_valid) begin
            pc_valid     <= 1'b1;
            instructions <= instr;
            updatedpc    <= next_pc;
            state        <= next_state;
            halted       <= (next_state == ST_HALT);
            fault        <= (next_state == ST_FAULT);
          end
        end
        ST_HALT: begin
          // Restart from the instruction after the HALT.
          if (resume) begin
            state     <= ST_RUN;
            halted    <= 1'b0;
            updatedpc <= updatedpc + PC_W'(1);
            pc_valid  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
